// File: rtl/cd_host_comm_pkg.sv
// ---------------------------------------------------------------------------
// cd_pkg : shared definitions for the CDD host-side link.
//   NIBBLE_COUNT    : nibbles per status / command frame
//   REG_FLAGS       : register index of the flag/status word
//   ST_* / cd_host_state_t : host FSM encodings (fixed legacy values)
//   cd_nibble_csum  : frame checksum, ~(sum + 5) truncated to a nibble
// ---------------------------------------------------------------------------
package cd_pkg;

  localparam int unsigned NIBBLE_COUNT = 10;
  localparam logic [3:0]  REG_FLAGS    = 4'd10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_S_WAIT_LO = 3'd1;
  localparam logic [2:0] ST_S_HOCK_HI = 3'd2;
  localparam logic [2:0] ST_S_WAIT_HI = 3'd3;
  localparam logic [2:0] ST_C_SETUP   = 3'd4;
  localparam logic [2:0] ST_C_HOCK_HI = 3'd5;
  localparam logic [2:0] ST_C_HOCK_LO = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    S_WAIT_LO = ST_S_WAIT_LO,
    S_HOCK_HI = ST_S_HOCK_HI,
    S_WAIT_HI = ST_S_WAIT_HI,
    C_SETUP   = ST_C_SETUP,
    C_HOCK_HI = ST_C_HOCK_HI,
    C_HOCK_LO = ST_C_HOCK_LO,
    DONE      = ST_DONE
  } cd_host_state_t;

  // Checksum nibble over an 8-bit accumulated sum of nibbles 0..8.
  function automatic logic [3:0] cd_nibble_csum(input logic [7:0] sum);
    logic [7:0] t;
    t = ~(sum + 8'd5);
    return t[3:0];
  endfunction

endpackage

// File: rtl/cd_host_comm_if.sv
// ---------------------------------------------------------------------------
// cd_host_comm_if : CDD link + CD controller register bus bundle.
//   CDD link : CD_nIRQ, CDCK, CDD_DOUT (from CDD), HOCK, CDD_DIN (to CDD)
//   Reg bus  : REG_WE, REG_ADDR, REG_WDATA (in), REG_RDATA (out)
//   Status   : FRAME_DONE (exchange complete pulse), BUSY
//   modport master : the host block (cd_host_comm)
//   modport slave  : the CDD / CPU side
// ---------------------------------------------------------------------------
interface cd_host_comm_if;
  import cd_pkg::*;

  logic       CD_nIRQ;
  logic       CDCK;
  logic [3:0] CDD_DOUT;
  logic       HOCK;
  logic [3:0] CDD_DIN;
  logic       REG_WE;
  logic [3:0] REG_ADDR;
  logic [3:0] REG_WDATA;
  logic [3:0] REG_RDATA;
  logic       FRAME_DONE;
  logic       BUSY;

  modport master (
    input  CD_nIRQ, CDCK, CDD_DOUT, REG_WE, REG_ADDR, REG_WDATA,
    output HOCK, CDD_DIN, REG_RDATA, FRAME_DONE, BUSY
  );

  modport slave (
    output CD_nIRQ, CDCK, CDD_DOUT, REG_WE, REG_ADDR, REG_WDATA,
    input  HOCK, CDD_DIN, REG_RDATA, FRAME_DONE, BUSY
  );

endinterface

// File: rtl/cd_host_comm_sync2.sv
// ---------------------------------------------------------------------------
// cd_sync2 : 2-flop synchronizer into the CLK_12M domain.
//   CLK_12M : destination clock
//   nRESET  : asynchronous active-low reset, flops load RST_VAL
//   i_d     : asynchronous input (WIDTH bits)
//   o_q     : synchronized output
// ---------------------------------------------------------------------------
module cd_sync2
  import cd_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_12M,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cd_host_comm.sv
// ---------------------------------------------------------------------------
// cd_host_comm : host-side master for the CDD nibble protocol.
// On each CDD IRQ it reads a 10-nibble status frame (CDCK-paced handshake
// on HOCK) and then writes the 10-nibble command frame (purely timed).
// Command/status buffers are visible on a small register bus.
//
// Ports:
//   CLK_12M : system clock
//   nRESET  : asynchronous active-low reset
//   bus     : cd_host_comm_if.master (CDD link, register bus, FRAME_DONE, BUSY)
//
// Register map: 0-9 write CMD[n] / read STATUS[n];
//               10 read {0, CSUM_ERR, TO_ERR, BUSY}, write bit0=1 clears flags;
//               11-15 read 0, writes ignored.
//
// Build option: CD_CHECKSUM_EN -- when defined, command nibble 9 is replaced
// by the checksum of nibbles 0..8 and received status nibble 9 is verified
// (CSUM_ERR). When undefined, CMD[9] is sent verbatim and CSUM_ERR reads 0.
// ---------------------------------------------------------------------------
module cd_host_comm
  import cd_pkg::*;
#(
  parameter int unsigned HOLD_CYC    = 144,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic           CLK_12M,
  input  logic           nRESET,
  cd_host_comm_if.master bus
);

  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    LAST_IDX  = 4'(NIBBLE_COUNT - 1);

  // Synchronized CDD inputs
  logic       w_irq;
  logic       w_cdck;
  logic [3:0] w_dout;

  // nIRQ idles high; resetting its synchronizer high avoids a false edge.
  cd_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_irq (
    .CLK_12M (CLK_12M),
    .nRESET  (nRESET),
    .i_d     (bus.CD_nIRQ),
    .o_q     (w_irq)
  );

  cd_sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_cdck (
    .CLK_12M (CLK_12M),
    .nRESET  (nRESET),
    .i_d     (bus.CDCK),
    .o_q     (w_cdck)
  );

  cd_sync2 #(.WIDTH(4), .RST_VAL(4'h0)) u_sync_dout (
    .CLK_12M (CLK_12M),
    .nRESET  (nRESET),
    .i_d     (bus.CDD_DOUT),
    .o_q     (w_dout)
  );

  cd_host_state_t r_state;
  logic [3:0]     r_idx;
  logic [HW-1:0]  r_hold;
  logic [TW-1:0]  r_wait;
  logic           r_holding;
  logic           r_irq_d;
  logic           r_hock;
  logic [3:0]     r_din;
  logic           r_frame_done;
  logic           r_busy;
  logic           r_to_err;
  logic [3:0]     r_cmd    [NIBBLE_COUNT];
  logic [3:0]     r_status [NIBBLE_COUNT];

  logic       w_irq_fall;
  logic       w_flags_clr;
  logic       w_cmd_wr;
  logic       w_wait_exp;
  logic [3:0] w_cmd_nibble;
  logic       w_csum_err;

  assign w_irq_fall  = r_irq_d & ~w_irq;
  assign w_cmd_wr    = bus.REG_WE && (bus.REG_ADDR < REG_FLAGS);
  assign w_flags_clr = bus.REG_WE && (bus.REG_ADDR == REG_FLAGS) && bus.REG_WDATA[0];
  assign w_wait_exp  = (r_wait == TO_LIMIT);

`ifdef CD_CHECKSUM_EN
  logic       r_csum_err;
  logic [7:0] w_cmd_sum;
  logic [7:0] w_stat_sum;

  always_comb begin
    w_cmd_sum  = '0;
    w_stat_sum = '0;
    for (int unsigned i = 0; i < NIBBLE_COUNT - 1; i++) begin
      w_cmd_sum  = w_cmd_sum  + {4'h0, r_cmd[i]};
      w_stat_sum = w_stat_sum + {4'h0, r_status[i]};
    end
  end

  assign w_cmd_nibble = (r_idx == LAST_IDX) ? cd_nibble_csum(w_cmd_sum) : r_cmd[r_idx];
  assign w_csum_err   = r_csum_err;
`else
  assign w_cmd_nibble = r_cmd[r_idx];
  assign w_csum_err   = 1'b0;
`endif

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_hold       <= '0;
      r_wait       <= '0;
      r_holding    <= 1'b0;
      r_irq_d      <= 1'b1;
      r_hock       <= 1'b0;
      r_din        <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_to_err     <= 1'b0;
`ifdef CD_CHECKSUM_EN
      r_csum_err   <= 1'b0;
`endif
      for (int unsigned i = 0; i < NIBBLE_COUNT; i++) begin
        r_cmd[i]    <= '0;
        r_status[i] <= '0;
      end
    end else begin
      r_irq_d      <= w_irq;
      r_frame_done <= 1'b0;

      if (w_cmd_wr) begin
        r_cmd[bus.REG_ADDR] <= bus.REG_WDATA;
      end

      unique case (r_state)
        IDLE: begin
          if (w_irq_fall) begin
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_holding <= 1'b0;
            r_wait    <= '0;
            r_state   <= S_WAIT_LO;
          end
        end

        // Wait for CDCK low (data valid), then settle HOLD_CYC cycles.
        S_WAIT_LO: begin
          if (r_holding) begin
            if (r_hold == '0) begin
              r_holding <= 1'b0;
              r_state   <= S_HOCK_HI;
            end else begin
              r_hold <= r_hold - HW'(1);
            end
          end else if (!w_cdck) begin
            r_holding <= 1'b1;
            r_hold    <= HOLD_LOAD;
          end else if (w_wait_exp) begin
            r_to_err  <= 1'b1;
            r_hock    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end

        S_HOCK_HI: begin
          r_hock  <= 1'b1;
          r_wait  <= '0;
          r_state <= S_WAIT_HI;
        end

        // Wait for CDCK high, latch the nibble, drop HOCK and settle.
        S_WAIT_HI: begin
          if (r_holding) begin
            if (r_hold == '0) begin
              r_holding <= 1'b0;
              if (r_idx == LAST_IDX) begin
                r_idx   <= '0;
                r_hold  <= HOLD_LOAD;
                r_state <= C_SETUP;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_wait  <= '0;
                r_state <= S_WAIT_LO;
              end
            end else begin
              r_hold <= r_hold - HW'(1);
            end
          end else if (w_cdck) begin
            r_status[r_idx] <= w_dout;
            r_hock          <= 1'b0;
            r_holding       <= 1'b1;
            r_hold          <= HOLD_LOAD;
`ifdef CD_CHECKSUM_EN
            if ((r_idx == LAST_IDX) && (w_dout != cd_nibble_csum(w_stat_sum))) begin
              r_csum_err <= 1'b1;
            end
`endif
          end else if (w_wait_exp) begin
            r_to_err  <= 1'b1;
            r_hock    <= 1'b0;
            r_busy    <= 1'b0;
            r_holding <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end

        // Nibble is captured on the entry cycle only, so CDD_DIN is stable
        // for the whole setup window before HOCK rises.
        C_SETUP: begin
          if (r_hold == HOLD_LOAD) begin
            r_din <= w_cmd_nibble;
          end
          if (r_hold == '0) begin
            r_hock  <= 1'b1;
            r_hold  <= HOLD_LOAD;
            r_state <= C_HOCK_HI;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end

        C_HOCK_HI: begin
          if (r_hold == '0) begin
            r_hock  <= 1'b0;
            r_hold  <= HOLD_LOAD;
            r_state <= C_HOCK_LO;
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end

        C_HOCK_LO: begin
          if (r_hold == '0) begin
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_hold  <= HOLD_LOAD;
              r_state <= C_SETUP;
            end
          end else begin
            r_hold <= r_hold - HW'(1);
          end
        end

        DONE: begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end

        default: begin
          r_hock  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase

      // Flag clear overrides any flag set in the same cycle.
      if (w_flags_clr) begin
        r_to_err   <= 1'b0;
`ifdef CD_CHECKSUM_EN
        r_csum_err <= 1'b0;
`endif
      end
    end
  end

  always_comb begin
    bus.REG_RDATA = '0;
    if (bus.REG_ADDR < REG_FLAGS) begin
      bus.REG_RDATA = r_status[bus.REG_ADDR];
    end else if (bus.REG_ADDR == REG_FLAGS) begin
      bus.REG_RDATA = {1'b0, w_csum_err, r_to_err, r_busy};
    end
  end

  assign bus.HOCK       = r_hock;
  assign bus.CDD_DIN    = r_din;
  assign bus.FRAME_DONE = r_frame_done;
  assign bus.BUSY       = r_busy;

endmodule

// File: tb/tb_cd_host_comm.sv
// ---------------------------------------------------------------------------
// tb_cd_host_comm : directed bench for cd_host_comm with a CDD model.
// Expected command nibbles are queued by the stimulus; a monitor pops them
// at every command-phase HOCK rising edge and also checks FRAME_DONE.
// ---------------------------------------------------------------------------
module tb_cd_host_comm;

`ifdef CD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic CLK_12M = 1'b0;
  logic nRESET;

  cd_host_comm_if bus ();

  cd_host_comm dut (
    .CLK_12M (CLK_12M),
    .nRESET  (nRESET),
    .bus     (bus)
  );

  always #5 CLK_12M = ~CLK_12M;

  int checks   = 0;
  int failures = 0;
  int hock_pulses = 0;
  int done_cnt    = 0;
  logic [3:0] exp_din_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: counts HOCK pulses per frame, scores command-phase nibbles.
  initial begin
    logic prev_hock;
    logic prev_busy;
    prev_hock = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK_12M);
      if (nRESET !== 1'b1) begin
        prev_hock = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (bus.BUSY && !prev_busy) hock_pulses = 0;
        if (bus.HOCK && !prev_hock) begin
          hock_pulses++;
          chk("busy_at_hock", bus.BUSY, 1);
          if (hock_pulses > 10) begin
            if (exp_din_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL din_unexpected: got %0h expected none", bus.CDD_DIN);
            end else begin
              chk($sformatf("din[%0d]", hock_pulses - 11), bus.CDD_DIN, exp_din_q.pop_front());
            end
          end
        end
        if (bus.FRAME_DONE) begin
          done_cnt++;
          chk("pulses_at_done", hock_pulses, 20);
        end
        prev_hock = bus.HOCK;
        prev_busy = bus.BUSY;
      end
    end
  end

  // sel 0: HOCK, sel 1: BUSY
  task automatic wait_for(input int sel, input logic lvl, input int maxc,
                          input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK_12M);
      if (((sel == 0) ? bus.HOCK : bus.BUSY) === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: got no event expected level %0d within %0d cycles", name, lvl, maxc);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [3:0] d);
    @(negedge CLK_12M);
    bus.REG_WE    = 1'b1;
    bus.REG_ADDR  = a;
    bus.REG_WDATA = d;
    @(negedge CLK_12M);
    bus.REG_WE    = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [3:0] d);
    bus.REG_ADDR = a;
    #1;
    d = bus.REG_RDATA;
  endtask

  // CDD side: raise IRQ and serve n_serve status nibbles.
  task automatic cdd_frame(input logic [9:0][3:0] nib, input int n_serve,
                           input int glitch_at, output bit ok);
    ok = 1'b1;
    bus.CDD_DOUT = nib[0];
    bus.CDCK     = 1'b0;
    repeat (5) @(negedge CLK_12M);
    bus.CD_nIRQ = 1'b0;
    for (int i = 0; i < n_serve; i++) begin
      bus.CDD_DOUT = nib[i];
      bus.CDCK     = 1'b0;
      wait_for(0, 1'b1, 2000, "hock_rise", ok);
      if (!ok) return;
      repeat (20) @(negedge CLK_12M);
      bus.CDCK = 1'b1;
      wait_for(0, 1'b0, 2000, "hock_fall", ok);
      if (!ok) return;
      if (i == 0) bus.CD_nIRQ = 1'b1;
      if (i == glitch_at) begin
        repeat (5) @(negedge CLK_12M);
        bus.CD_nIRQ = 1'b0;
        repeat (10) @(negedge CLK_12M);
        bus.CD_nIRQ = 1'b1;
      end
      repeat (20) @(negedge CLK_12M);
    end
  endtask

  task automatic check_status(input string tag, input logic [9:0][3:0] nib);
    logic [3:0] d;
    for (int i = 0; i < 10; i++) begin
      reg_read(4'(i), d);
      chk($sformatf("%s_status[%0d]", tag, i), d, nib[i]);
    end
  endtask

  task automatic finish_frame(input string tag, input int exp_done);
    bit ok;
    wait_for(1, 1'b0, 8000, {tag, "_busy_fall"}, ok);
    repeat (2) @(negedge CLK_12M);
    chk({tag, "_done_cnt"}, done_cnt, exp_done);
  endtask

  initial begin
    logic [9:0][3:0] nib;
    logic [3:0] d;
    bit ok;
    int n;

    bus.CD_nIRQ   = 1'b1;
    bus.CDCK      = 1'b1;
    bus.CDD_DOUT  = 4'h0;
    bus.REG_WE    = 1'b0;
    bus.REG_ADDR  = 4'h0;
    bus.REG_WDATA = 4'h0;
    nRESET = 1'b0;
    repeat (5) @(negedge CLK_12M);
    nRESET = 1'b1;
    repeat (3) @(negedge CLK_12M);

    // Reset state
    chk("rst_hock", bus.HOCK, 0);
    chk("rst_din", bus.CDD_DIN, 0);
    chk("rst_done", bus.FRAME_DONE, 0);
    chk("rst_busy", bus.BUSY, 0);
    reg_read(4'd10, d); chk("rst_flags", d, 0);
    reg_read(4'd3, d);  chk("rst_status3", d, 0);
    reg_read(4'd11, d); chk("rst_addr11", d, 0);

    // Frame 1: CMD 0..9, status F..6
    for (int i = 0; i < 10; i++) reg_write(4'(i), 4'(i));
    reg_write(4'd11, 4'hF);
    reg_read(4'd11, d); chk("addr11_after_write", d, 0);
    for (int i = 0; i < 9; i++) exp_din_q.push_back(4'(i));
    exp_din_q.push_back(CSUM ? 4'h6 : 4'h9);
    for (int i = 0; i < 10; i++) nib[i] = 4'(15 - i);
    cdd_frame(nib, 10, -1, ok);
    reg_read(4'd10, d); chk("f1_busy_flag", d[0], 1);
    finish_frame("f1", 1);
    check_status("f1", nib);
    reg_read(4'd10, d); chk("f1_flags", d, CSUM ? 4'b0100 : 4'b0000);
    reg_write(4'd10, 4'h0);
    reg_read(4'd10, d); chk("f1_flags_noclr", d, CSUM ? 4'b0100 : 4'b0000);
    reg_write(4'd10, 4'h1);
    reg_read(4'd10, d); chk("f1_flags_clr", d, 0);

    // Frame 2: second IRQ edge mid-frame is ignored; valid checksum
    for (int i = 0; i < 9; i++) exp_din_q.push_back(4'(i));
    exp_din_q.push_back(CSUM ? 4'h6 : 4'h9);
    for (int i = 0; i < 9; i++) nib[i] = 4'((i * 3) % 16);
    nib[9] = 4'hE;
    cdd_frame(nib, 10, 3, ok);
    finish_frame("f2", 2);
    repeat (400) @(negedge CLK_12M);
    chk("f2_busy_after_glitch", bus.BUSY, 0);
    chk("f2_single_done", done_cnt, 2);
    check_status("f2", nib);
    reg_read(4'd10, d); chk("f2_flags", d, 0);

    // Frame 3: CMD[0..8]=1, CMD[9]=7; bad status checksum
    for (int i = 0; i < 9; i++) reg_write(4'(i), 4'h1);
    reg_write(4'd9, 4'h7);
    for (int i = 0; i < 9; i++) exp_din_q.push_back(4'h1);
    exp_din_q.push_back(CSUM ? 4'h1 : 4'h7);
    for (int i = 0; i < 9; i++) nib[i] = 4'h0;
    nib[9] = 4'hB;
    cdd_frame(nib, 10, -1, ok);
    finish_frame("f3", 3);
    check_status("f3", nib);
    reg_read(4'd10, d); chk("f3_flags", d, CSUM ? 4'b0100 : 4'b0000);
    reg_write(4'd10, 4'h1);

    // Timeout: CDCK never rises after HOCK
    bus.CDD_DOUT = 4'h3;
    bus.CDCK     = 1'b0;
    repeat (5) @(negedge CLK_12M);
    bus.CD_nIRQ = 1'b0;
    wait_for(0, 1'b1, 2000, "to_hock_rise", ok);
    bus.CD_nIRQ = 1'b1;
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK_12M);
      n++;
      if (bus.BUSY === 1'b0) break;
    end
    chk_range("to_latency", n, 4094, 4100);
    chk("to_hock", bus.HOCK, 0);
    reg_read(4'd10, d); chk("to_flags", d, 4'b0010);
    repeat (2) @(negedge CLK_12M);
    chk("to_no_done", done_cnt, 3);
    reg_write(4'd10, 4'h1);
    reg_read(4'd10, d); chk("to_flags_clr", d, 0);

    // Reset mid-frame after status nibble 4
    for (int i = 0; i < 10; i++) reg_write(4'(i), 4'h5);
    for (int i = 0; i < 10; i++) nib[i] = 4'(i + 1);
    cdd_frame(nib, 5, -1, ok);
    bus.CDD_DOUT = nib[5];
    bus.CDCK     = 1'b0;
    wait_for(0, 1'b1, 2000, "rm_hock_rise", ok);
    reg_read(4'd4, d); chk("rm_status4_pre", d, 4'h5);
    nRESET = 1'b0;
    #1;
    chk("rm_hock", bus.HOCK, 0);
    chk("rm_busy", bus.BUSY, 0);
    reg_read(4'd4, d); chk("rm_status4", d, 0);
    reg_read(4'd0, d); chk("rm_status0", d, 0);
    reg_read(4'd10, d); chk("rm_flags", d, 0);
    repeat (3) @(negedge CLK_12M);
    nRESET = 1'b1;
    repeat (3) @(negedge CLK_12M);

    // Clean frame after reset: CMD buffer was cleared
    for (int i = 0; i < 9; i++) exp_din_q.push_back(4'h0);
    exp_din_q.push_back(CSUM ? 4'hA : 4'h0);
    for (int i = 0; i < 9; i++) nib[i] = 4'(9 - i);
    nib[9] = 4'hD;
    cdd_frame(nib, 10, -1, ok);
    finish_frame("f4", 4);
    check_status("f4", nib);
    reg_read(4'd10, d); chk("f4_flags", d, 0);

    chk("queue_empty", exp_din_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
